hs_dpath_vsfr: RTL and testbench
================================

HS_DPATH_VSFR -- requirements
Module: hs_dpath_vsfr

Interface
REQ-001 The block SHALL have parameter DATA_TYPE, default logic, meaning the payload type carried per stage.
REQ-002 The block SHALL have parameter RESET_VALUE, of type DATA_TYPE, default 1'b0, meaning the value loaded into every data stage on reset.
REQ-003 The block SHALL have parameter DEPTH, int, default 2, range 1..1024, meaning the number of register stages.
REQ-004 The block SHALL have parameter COLLAPSE, bit, default 1, where 1 selects bubble-collapsing stalls and 0 selects a global stall.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port areset, input, 1 bit, an asynchronous active-high reset.
REQ-007 The block SHALL have port flush, input, 1 bit, a synchronous discard of all in-flight items.
REQ-008 The block SHALL have port s_valid, input, 1 bit, signalling that upstream data is present.
REQ-009 The block SHALL have port s_ready, output, 1 bit, signalling that the block accepts s_data this cycle.
REQ-010 The block SHALL have port s_data, input, DATA_TYPE, the upstream payload.
REQ-011 The block SHALL have port m_valid, output, 1 bit, equal to the valid bit of stage DEPTH-1.
REQ-012 The block SHALL have port m_ready, input, 1 bit, signalling that downstream accepts m_data.
REQ-013 The block SHALL have port m_data, output, DATA_TYPE, equal to the data of stage DEPTH-1.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits, giving the number of valid stages.

Function
REQ-015 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a data register d[i]; stage 0 is fed by s_*, and stage i by stage i-1.
REQ-016 In COLLAPSE=1 mode, the stage enable SHALL be en[DEPTH-1] = !v[DEPTH-1] | m_ready and en[i] = !v[i] | en[i+1] for i < DEPTH-1.
REQ-017 In COLLAPSE=0 mode, all stage enables SHALL equal !m_valid | m_ready.
REQ-018 s_ready SHALL equal en[0] & !flush; a transfer occurs at a rising edge when s_valid & s_ready, and likewise when m_valid & m_ready.
REQ-019 On an enabled edge, v[i] SHALL take the source valid bit (s_valid & !flush for stage 0); d[i] SHALL load only when the source valid bit is 1, otherwise it holds its value.
REQ-020 A disabled stage SHALL hold both v[i] and d[i].
REQ-021 With m_ready=1 held, an item accepted at edge N SHALL appear on m_valid/m_data after edge N+DEPTH-1, so that it is presented DEPTH cycles after it was offered.
REQ-022 Item order SHALL be preserved, with no drop or duplication absent flush.
REQ-023 In COLLAPSE=1 mode, an upstream bubble SHALL be absorbed while the output is stalled, so that up to DEPTH items can be held with m_ready=0.
REQ-024 In COLLAPSE=0 mode, bubbles SHALL never be removed.
REQ-025 When flush=1 at an edge, all v[i] SHALL clear to 0 and count SHALL become 0 on that edge; the d[i] registers hold their values.
REQ-026 During a flush cycle, s_ready SHALL be 0 and no input SHALL be accepted; m_valid/m_data SHALL still reflect the pre-flush state, and a handshake on them counts as delivered.
REQ-027 count SHALL be registered and SHALL update by +1 on input accept, -1 on output accept, and 0 net when both occur in the same cycle.
REQ-028 count SHALL saturate at DEPTH and SHALL never wrap.
REQ-029 When DEPTH=1, the block SHALL behave as a single-entry register slice, with s_ready = !v[0] | m_ready.
REQ-030 The s_ready combinational path from m_ready is permitted; the bench SHALL drive m_ready independently of s_ready.
REQ-031 m_data while m_valid=0 SHALL be don't-care and SHALL not be checked.

Reset
REQ-032 On areset=1, asynchronously: all v[i] SHALL clear to 0, all d[i] SHALL equal RESET_VALUE, and count SHALL be 0.
REQ-033 After reset, m_valid SHALL be 0, m_data SHALL equal RESET_VALUE, and s_ready SHALL be 1.
REQ-034 Reset asserted mid-stream SHALL discard all items with no partial transfer; after deassertion, the first accepted item SHALL appear with nominal latency.
REQ-035 No output SHALL toggle from X after reset release; all state SHALL be resettable.

Verification
REQ-036 The bench SHALL cover streaming: DEPTH=4, m_ready=1, s_data=1,2,3,...,10 back-to-back -> m_data 1..10 in order, first item presented 4 cycles after offer, count steady at 4.
REQ-037 The bench SHALL cover collapse: DEPTH=4, COLLAPSE=1, alternating s_valid, m_ready=0 -> s_ready stays 1 until count=4, then 0; release m_ready -> 4 items out on consecutive cycles.
REQ-038 The bench SHALL cover global stall: COLLAPSE=0, same stimulus as REQ-037 -> bubbles retained, s_ready = m_ready once m_valid=1, item order intact.
REQ-039 The bench SHALL cover flush: count=3 with m_valid=1, flush for 1 cycle with s_valid=1 -> s_ready=0, input dropped, m_valid=0 and count=0 next cycle.
REQ-040 The bench SHALL cover async reset: assert areset between edges with DEPTH=3 full -> m_valid=0 and m_data=RESET_VALUE immediately; post-release item 0xA5 appears after 3 cycles.
REQ-041 The bench SHALL cover DEPTH=1: random s_valid/m_ready over 1000 cycles -> scoreboard matches, count in {0,1}, full throughput when m_ready=1.

Source files
------------

// File: rtl/hs_dpath_vsfr.sv
// rtl/hs_dpath_vsfr.sv - valid/ready register pipeline with bubble-collapsing or global stall
module hs_dpath_vsfr #(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = 1'b0,
    parameter int       DEPTH       = 2,
    parameter bit       COLLAPSE    = 1'b1
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  DATA_TYPE                   s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output DATA_TYPE                   m_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] v_q, v_d, en;
    DATA_TYPE         d_q [DEPTH];
    DATA_TYPE         d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             full_run, src_v, in_acc, out_acc;

    // A stage may move when any stage from it to the output is empty, or the output drains.
    always_comb begin
        full_run = 1'b1;
        en       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_run = full_run & v_q[i];
            en[i]    = COLLAPSE ? (!full_run || m_ready) : (!v_q[DEPTH-1] || m_ready);
        end
    end

    assign s_ready = en[0] & ~flush;
    assign src_v   = s_valid & ~flush;
    assign in_acc  = s_valid & s_ready;
    assign out_acc = v_q[DEPTH-1] & m_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (en[0]) begin
                v_d[0] = src_v;
                if (src_v) begin
                    d_d[0] = s_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (en[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_acc && !out_acc && count_q != FULL) begin
            count_d = count_q + 1'b1;
        end else if (out_acc && !in_acc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RESET_VALUE;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign m_valid = v_q[DEPTH-1];
    assign m_data  = d_q[DEPTH-1];
    assign count   = count_q;
endmodule

// File: tb/tb_hs_dpath_vsfr.sv
// tb/tb_hs_dpath_vsfr.sv - self-checking bench for hs_dpath_vsfr
module tb_hs_dpath_vsfr;
    typedef logic [7:0] byte_t;
    typedef struct { byte_t data; int edge_i; } item_t;
    typedef struct { logic v; byte_t data; } slot_t;
    typedef struct { logic sv; byte_t sd; logic mr; logic mv; byte_t md; int cnt; logic sr; } vec_t;

    localparam byte_t RV_C = 8'hC0;
    localparam byte_t RV_G = 8'h0F;
    localparam byte_t RV_B = 8'h3C;
    localparam byte_t RV_D = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic areset;

    logic a_s_valid, a_m_ready, a_flush;
    byte_t a_s_data;
    logic c_s_ready, c_m_valid, g_s_ready, g_m_valid;
    byte_t c_m_data, g_m_data;
    logic [2:0] c_count, g_count;

    logic b_s_valid, b_m_ready, b_flush, b_s_ready, b_m_valid;
    byte_t b_s_data, b_m_data;
    logic [1:0] b_count;

    logic d_s_valid, d_m_ready, d_flush, d_s_ready, d_m_valid;
    byte_t d_s_data, d_m_data;
    logic d_count;

    hs_dpath_vsfr #(.DATA_TYPE(byte_t), .RESET_VALUE(RV_C), .DEPTH(4), .COLLAPSE(1'b1)) u_c (
        .clk(clk), .areset(areset), .flush(a_flush), .s_valid(a_s_valid), .s_ready(c_s_ready),
        .s_data(a_s_data), .m_valid(c_m_valid), .m_ready(a_m_ready), .m_data(c_m_data), .count(c_count));
    hs_dpath_vsfr #(.DATA_TYPE(byte_t), .RESET_VALUE(RV_G), .DEPTH(4), .COLLAPSE(1'b0)) u_g (
        .clk(clk), .areset(areset), .flush(a_flush), .s_valid(a_s_valid), .s_ready(g_s_ready),
        .s_data(a_s_data), .m_valid(g_m_valid), .m_ready(a_m_ready), .m_data(g_m_data), .count(g_count));
    hs_dpath_vsfr #(.DATA_TYPE(byte_t), .RESET_VALUE(RV_B), .DEPTH(3), .COLLAPSE(1'b1)) u_b (
        .clk(clk), .areset(areset), .flush(b_flush), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .count(b_count));
    hs_dpath_vsfr #(.DATA_TYPE(byte_t), .RESET_VALUE(RV_D), .DEPTH(1), .COLLAPSE(1'b1)) u_d (
        .clk(clk), .areset(areset), .flush(d_flush), .s_valid(d_s_valid), .s_ready(d_s_ready),
        .s_data(d_s_data), .m_valid(d_m_valid), .m_ready(d_m_ready), .m_data(d_m_data), .count(d_count));

    // Collapsing pipes: queue of items in flight; the oldest is visible once it is DEPTH edges old.
    item_t cq[$], bq[$], dq[$];
    // Global-stall pipe: fixed-length line of slots, bubbles included, shifted as a whole.
    slot_t gq[$];
    int    edge_n, n_cmp, n_bad;
    logic  c_in, c_out, b_in, b_out, d_in, d_out, g_en;
    vec_t  tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic chk_col(input string nm, input int dep, input int qs, input item_t fr,
                           input logic sv, input logic mr, input logic fl,
                           input logic sr, input logic mv, input byte_t md, input logic [31:0] cnt,
                           output logic acc_in, output logic acc_out);
        logic esr, emv;
        esr = ((qs < dep) || mr) && !fl;
        emv = (qs > 0) && (edge_n >= fr.edge_i + dep);
        chk({nm, ".s_ready"}, sr, esr);
        chk({nm, ".m_valid"}, mv, emv);
        chk({nm, ".count"}, cnt, qs);
        if (emv) chk({nm, ".m_data"}, md, fr.data);
        acc_in  = sv && esr;
        acc_out = emv && mr;
    endtask

    task automatic reset_models();
        cq.delete(); bq.delete(); dq.delete(); gq.delete();
        for (int i = 0; i < 4; i++) gq.push_back('{1'b0, 8'h00});
    endtask

    task automatic idle();
        a_s_valid = 0; a_s_data = 0; a_m_ready = 0; a_flush = 0;
        b_s_valid = 0; b_s_data = 0; b_m_ready = 0; b_flush = 0;
        d_s_valid = 0; d_s_data = 0; d_m_ready = 0; d_flush = 0;
    endtask

    task automatic sample();
        item_t f;
        int    gc;
        @(negedge clk); #1;
        f = '{8'h00, 0}; if (cq.size() > 0) f = cq[0];
        chk_col("c", 4, cq.size(), f, a_s_valid, a_m_ready, a_flush, c_s_ready, c_m_valid, c_m_data, c_count, c_in, c_out);
        f = '{8'h00, 0}; if (bq.size() > 0) f = bq[0];
        chk_col("b", 3, bq.size(), f, b_s_valid, b_m_ready, b_flush, b_s_ready, b_m_valid, b_m_data, b_count, b_in, b_out);
        f = '{8'h00, 0}; if (dq.size() > 0) f = dq[0];
        chk_col("d", 1, dq.size(), f, d_s_valid, d_m_ready, d_flush, d_s_ready, d_m_valid, d_m_data, d_count, d_in, d_out);
        gc = 0;
        foreach (gq[i]) gc += int'(gq[i].v);
        g_en = !gq[3].v || a_m_ready;
        chk("g.s_ready", g_s_ready, g_en && !a_flush);
        chk("g.m_valid", g_m_valid, gq[3].v);
        chk("g.count", g_count, gc);
        if (gq[3].v) chk("g.m_data", g_m_data, gq[3].data);
    endtask

    task automatic advance();
        @(posedge clk); #1;
        if (a_flush) cq.delete();
        else begin
            if (c_out) void'(cq.pop_front());
            if (c_in) cq.push_back('{a_s_data, edge_n});
        end
        if (b_flush) bq.delete();
        else begin
            if (b_out) void'(bq.pop_front());
            if (b_in) bq.push_back('{b_s_data, edge_n});
        end
        if (d_flush) dq.delete();
        else begin
            if (d_out) void'(dq.pop_front());
            if (d_in) dq.push_back('{d_s_data, edge_n});
        end
        if (a_flush) begin
            foreach (gq[i]) gq[i].v = 1'b0;
        end else if (g_en) begin
            void'(gq.pop_back());
            gq.push_front('{a_s_valid, a_s_data});
        end
        edge_n++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; edge_n = 0;
        idle();
        reset_models();
        areset = 1'b1;
        #12;
        chk("rst.c.m_valid", c_m_valid, 0); chk("rst.c.m_data", c_m_data, RV_C);
        chk("rst.c.count", c_count, 0);     chk("rst.c.s_ready", c_s_ready, 1);
        chk("rst.g.m_valid", g_m_valid, 0); chk("rst.g.m_data", g_m_data, RV_G);
        chk("rst.b.m_data", b_m_data, RV_B); chk("rst.d.m_data", d_m_data, RV_D);
        chk("rst.d.s_ready", d_s_ready, 1);
        #10 areset = 1'b0;
        @(posedge clk); #1;

        // Streaming 1..10 with m_ready held high; expected values from latency DEPTH=4.
        for (int k = 0; k < 16; k++) begin
            int acc, dlv;
            acc = (k < 10) ? k : 10;
            dlv = (k < 4) ? 0 : ((k - 4 > 10) ? 10 : k - 4);
            tbl[k] = '{(k < 10), (k < 10) ? byte_t'(k + 1) : 8'h00, 1'b1,
                       (k >= 4 && k < 14), byte_t'(k - 3), acc - dlv, 1'b1};
        end
        for (int k = 0; k < 16; k++) begin
            a_s_valid = tbl[k].sv; a_s_data = tbl[k].sd; a_m_ready = tbl[k].mr;
            sample();
            chk("tbl.c.m_valid", c_m_valid, tbl[k].mv);
            chk("tbl.g.m_valid", g_m_valid, tbl[k].mv);
            if (tbl[k].mv) begin
                chk("tbl.c.m_data", c_m_data, tbl[k].md);
                chk("tbl.g.m_data", g_m_data, tbl[k].md);
            end
            chk("tbl.c.count", c_count, tbl[k].cnt);
            chk("tbl.c.s_ready", c_s_ready, tbl[k].sr);
            advance();
        end

        // Alternating s_valid with output stalled, then released.
        for (int k = 0; k < 16; k++) begin
            a_m_ready = (k >= 9);
            a_s_valid = (k < 9) && (k % 2 == 0);
            a_s_data  = byte_t'(8'h10 + k);
            sample();
            if (k <= 8) chk("col.s_ready", c_s_ready, (k < 7));
            if (k == 7) chk("col.count_full", c_count, 4);
            if (k >= 9 && k < 13) begin
                chk("col.drain_v", c_m_valid, 1);
                chk("col.drain_d", c_m_data, 8'h10 + 2 * (k - 9));
            end
            if (gq[3].v) chk("gst.s_ready_eq_m_ready", g_s_ready, a_m_ready);
            if (k == 8) chk("gst.count", g_count, 2);
            if (k == 10) chk("gst.bubble_kept", g_m_valid, 0);
            if (k == 11) chk("gst.second_item", g_m_data, 8'h12);
            advance();
        end
        idle();

        // Flush with three items held and a new offer in the flush cycle.
        for (int k = 0; k < 7; k++) begin
            a_m_ready = (k == 6);
            a_flush   = (k == 4);
            a_s_valid = (k < 3) || (k == 4);
            a_s_data  = (k == 4) ? 8'h99 : byte_t'(8'h21 + k);
            sample();
            if (k == 4) begin
                chk("flush.count_before", c_count, 3);
                chk("flush.m_valid_before", c_m_valid, 1);
                chk("flush.s_ready", c_s_ready, 0);
            end
            if (k == 5) begin
                chk("flush.m_valid_after", c_m_valid, 0);
                chk("flush.count_after", c_count, 0);
            end
            advance();
        end
        idle();

        // Async reset between edges with the DEPTH=3 pipe full.
        for (int k = 0; k < 4; k++) begin
            b_s_valid = (k < 3);
            b_s_data  = byte_t'(8'h31 + k);
            sample();
            if (k == 3) begin
                chk("areset.full_count", b_count, 3);
                chk("areset.full_valid", b_m_valid, 1);
            end else advance();
        end
        areset = 1'b1; #1;
        chk("areset.m_valid", b_m_valid, 0);
        chk("areset.m_data", b_m_data, RV_B);
        chk("areset.count", b_count, 0);
        chk("areset.s_ready", b_s_ready, 1);
        #1 areset = 1'b0;
        idle();
        reset_models();
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            b_m_ready = 1'b1;
            b_s_valid = (k == 0);
            b_s_data  = 8'hA5;
            sample();
            if (k == 2) chk("areset.post_early", b_m_valid, 0);
            if (k == 3) begin
                chk("areset.post_valid", b_m_valid, 1);
                chk("areset.post_data", b_m_data, 8'hA5);
            end
            advance();
        end

        // Random traffic on every instance against the models.
        for (int k = 0; k < 1000; k++) begin
            a_s_valid = 1'($urandom_range(0, 1));
            a_s_data  = byte_t'($urandom);
            a_m_ready = ($urandom_range(0, 3) != 0) ^ (k % 200 > 150);
            a_flush   = ($urandom_range(0, 31) == 0);
            b_s_valid = 1'($urandom_range(0, 1));
            b_s_data  = byte_t'($urandom);
            b_m_ready = 1'($urandom_range(0, 1));
            b_flush   = ($urandom_range(0, 47) == 0);
            d_s_valid = ($urandom_range(0, 3) != 0);
            d_s_data  = byte_t'($urandom);
            d_m_ready = (k % 100 < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            d_flush   = 1'b0;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end
endmodule
